// File: rtl/eth_10g_mac_tx_pause_timer.sv
// TX pause timer: counts down received pause quanta and holds the TX stream at frame boundaries.
// Optional `ETH_10G_TX_PAUSE_STATS_EN adds a saturating pause_req_count output.
module eth_10g_mac_tx_pause_timer #(
  parameter int unsigned QUANTA_CYCLES = 8,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned EMPTY_W       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pause_valid,
  input  logic [15:0]        pause_data,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  input  logic               out_ready,
  output logic               pause_active
`ifdef ETH_10G_TX_PAUSE_STATS_EN
  ,
  output logic [15:0]        pause_req_count
`endif
);

  localparam logic [7:0] SUB_LAST = 8'(QUANTA_CYCLES - 1);

  logic [15:0] quanta_cnt_q, quanta_cnt_d;
  logic [7:0]  sub_cnt_q, sub_cnt_d;
  logic        pause_active_q, pause_active_d;
  logic        in_frame_q, in_frame_d;
  logic        gate_open;
  logic        beat_accept;

  // A frame already in flight is never cut; only a fresh sop waits for the timer.
  assign gate_open         = !pause_active_q || in_frame_q;
  assign out_valid         = in_valid && gate_open;
  assign in_ready          = out_ready && gate_open;
  assign out_data          = in_data;
  assign out_startofpacket = in_startofpacket;
  assign out_endofpacket   = in_endofpacket;
  assign out_empty         = in_empty;
  assign pause_active      = pause_active_q;
  assign beat_accept       = in_valid && in_ready;

  always_comb begin
    quanta_cnt_d = quanta_cnt_q;
    sub_cnt_d    = sub_cnt_q;
    if (pause_valid) begin
      quanta_cnt_d = pause_data;
      sub_cnt_d    = 8'd0;
    end else if (quanta_cnt_q != 16'd0) begin
      if (sub_cnt_q == SUB_LAST) begin
        sub_cnt_d    = 8'd0;
        quanta_cnt_d = quanta_cnt_q - 16'd1;
      end else begin
        sub_cnt_d = sub_cnt_q + 8'd1;
      end
    end
    // Registered copy of (quanta_cnt != 0), so it tracks the counter edge-for-edge.
    pause_active_d = (quanta_cnt_d != 16'd0);
  end

  always_comb begin
    in_frame_d = in_frame_q;
    if (beat_accept) begin
      if (in_endofpacket) begin
        in_frame_d = 1'b0;
      end else if (in_startofpacket) begin
        in_frame_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quanta_cnt_q   <= 16'd0;
      sub_cnt_q      <= 8'd0;
      pause_active_q <= 1'b0;
      in_frame_q     <= 1'b0;
    end else begin
      quanta_cnt_q   <= quanta_cnt_d;
      sub_cnt_q      <= sub_cnt_d;
      pause_active_q <= pause_active_d;
      in_frame_q     <= in_frame_d;
    end
  end

`ifdef ETH_10G_TX_PAUSE_STATS_EN
  logic [15:0] req_cnt_q, req_cnt_d;

  always_comb begin
    req_cnt_d = req_cnt_q;
    if (pause_valid && (pause_data != 16'd0) && (req_cnt_q != 16'hFFFF)) begin
      req_cnt_d = req_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_cnt_q <= 16'd0;
    end else begin
      req_cnt_q <= req_cnt_d;
    end
  end

  assign pause_req_count = req_cnt_q;
`endif

endmodule

// File: tb/tb_eth_10g_mac_tx_pause_timer.sv
// Self-checking bench for eth_10g_mac_tx_pause_timer (default parameters).
// Define ETH_10G_TX_PAUSE_STATS_EN to also exercise pause_req_count.
module tb_eth_10g_mac_tx_pause_timer;

  logic        clk;
  logic        reset;
  logic        pause_valid;
  logic [15:0] pause_data;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [2:0]  in_empty;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [2:0]  out_empty;
  logic        out_ready;
  logic        pause_active;
`ifdef ETH_10G_TX_PAUSE_STATS_EN
  logic [15:0] pause_req_count;
`endif

  eth_10g_mac_tx_pause_timer #(
    .QUANTA_CYCLES(8),
    .DATA_W(64),
    .EMPTY_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pause_valid(pause_valid),
    .pause_data(pause_data),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .in_empty(in_empty),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_empty(out_empty),
    .out_ready(out_ready),
    .pause_active(pause_active)
`ifdef ETH_10G_TX_PAUSE_STATS_EN
    ,
    .pause_req_count(pause_req_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] q);
    pause_valid = 1'b1;
    pause_data  = q;
    cyc();
    pause_valid = 1'b0;
  endtask

  task automatic count_active(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!pause_active) break;
      n++;
      cyc();
    end
    cyc();
  endtask

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  empty;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t sb_q[$];
  logic  sb_en = 1'b0;
  int    sb_popped = 0;

  // Scoreboard monitor for the backpressure test.
  always @(negedge clk) begin
    if (sb_en) begin
      check("bp_ready_mirror", in_ready, out_ready);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bp_extra_beat: got beat %0h expected none", out_data);
        end else begin
          beat_t exp_b;
          exp_b = sb_q.pop_front();
          sb_popped++;
          check("bp_beat", {out_data, out_empty, out_startofpacket, out_endofpacket}, exp_b);
        end
      end
    end
  end

  typedef struct packed {
    logic        iv;
    logic        ordy;
    logic        sop;
    logic        eop;
    logic [63:0] data;
    logic [2:0]  empty;
    logic        exp_ov;
    logic        exp_ir;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rel;
    int stalls;
    int nz_list[5];
    vec_t v;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_0001, 3'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567, 3'd1, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'hA5A5_5A5A_F0F0_0F0F, 3'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h1111_2222_3333_4444, 3'd3, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000, 3'd7, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 3'd4, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'hCAFE_F00D_0000_0001, 3'd5, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_0002, 3'd6, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0003, 3'd0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'd2, 1'b0, 1'b0};
    nz_list = '{5, 0, 7, 0, 1};

    reset = 1'b1; pause_valid = 1'b0; pause_data = 16'd0;
    in_valid = 1'b0; in_data = 64'd0; in_startofpacket = 1'b0;
    in_endofpacket = 1'b0; in_empty = 3'd0; out_ready = 1'b1;

    // Reset: stream passes straight through while the timer is cleared.
    cyc();
    in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b1;
    @(negedge clk);
    check("rst_out_valid_follows", out_valid, 1'b1);
    check("rst_in_ready_follows", in_ready, 1'b1);
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_pause_active", pause_active, 1'b0);
`ifdef ETH_10G_TX_PAUSE_STATS_EN
    check("rst_stats", pause_req_count, 16'd0);
`endif
    cyc();

    // Table: combinational gate, unpaused then paused.
    for (int i = 0; i < 10; i++) begin
      if (i == 6) begin
        in_valid = 1'b0;
        load(16'd50);
      end
      v = tbl[i];
      in_valid = v.iv; out_ready = v.ordy; in_startofpacket = v.sop;
      in_endofpacket = v.eop; in_data = v.data; in_empty = v.empty;
      @(negedge clk);
      check($sformatf("tbl%0d_ctrl", i), {out_valid, in_ready}, {v.exp_ov, v.exp_ir});
      check($sformatf("tbl%0d_data", i),
            {out_data, out_empty, out_startofpacket, out_endofpacket},
            {v.data, v.empty, v.sop, v.eop});
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    load(16'd0);
    @(negedge clk);
    check("tbl_cancel", pause_active, 1'b0);
    cyc();

`ifdef ETH_10G_TX_PAUSE_STATS_EN
    // Stats: only non-zero pause beats count, one cycle after the beat.
    for (int i = 0; i < 5; i++) begin
      pause_valid = 1'b1;
      pause_data  = 16'(nz_list[i]);
      @(negedge clk);
      if (i == 1) check("stats_latency", pause_req_count, 16'd1);
      cyc();
    end
    pause_valid = 1'b0;
    @(negedge clk);
    check("stats_count3", pause_req_count, 16'd3);
    cyc();
    for (int k = 0; k < 65532; k++) begin
      pause_valid = 1'b1; pause_data = 16'd1;
      cyc();
    end
    pause_valid = 1'b0;
    @(negedge clk);
    check("stats_reach_max", pause_req_count, 16'hFFFF);
    cyc();
    for (int k = 0; k < 4; k++) begin
      pause_valid = 1'b1; pause_data = 16'd9;
      cyc();
    end
    pause_valid = 1'b0;
    @(negedge clk);
    check("stats_saturate", pause_req_count, 16'hFFFF);
    cyc();
    load(16'd0);
`endif

    // Basic pause: 3 quanta, sop held then released.
    load(16'd3);
    in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b0;
    in_data = 64'h1234; in_empty = 3'd0;
    n = 0; stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!pause_active) break;
      n++;
      if (in_ready || out_valid) stalls++;
      cyc();
    end
    check("basic_len", n, 24);
    check("basic_hold", stalls, 0);
    check("basic_release", {in_ready, out_valid}, 2'b11);
    cyc();
    in_startofpacket = 1'b0; in_endofpacket = 1'b1;
    @(negedge clk);
    check("basic_eop", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0; in_endofpacket = 1'b0;

    // Mid-frame pause: 5 beats unstalled, next sop released 17 cycles after load cycle.
    stalls = 0;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1; in_startofpacket = (b == 0); in_endofpacket = (b == 4);
      in_data = 64'(b + 100);
      if (b == 1) begin
        pause_valid = 1'b1; pause_data = 16'd2;
      end
      @(negedge clk);
      if (!in_ready) stalls++;
      cyc();
      pause_valid = 1'b0;
    end
    check("mid_no_stall", stalls, 0);
    in_startofpacket = 1'b1; in_endofpacket = 1'b1;
    rel = 4;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) break;
      rel++;
      cyc();
    end
    check("mid_next_sop_release", rel, 17);
    cyc();
    in_valid = 1'b0;

    // Reload mid-pause restarts the count.
    load(16'd10);
    repeat (19) cyc();
    load(16'd4);
    count_active(n);
    check("reload_len", n, 32);

    // Reload exactly at the last wrap of quanta 1: the load wins.
    load(16'd1);
    repeat (7) cyc();
    load(16'd2);
    count_active(n);
    check("reload_at_wrap", n, 16);

    // Cancel with zero.
    load(16'd5);
    repeat (3) cyc();
    @(negedge clk);
    check("cancel_before", pause_active, 1'b1);
    pause_valid = 1'b1; pause_data = 16'd0;
    cyc();
    pause_valid = 1'b0;
    @(negedge clk);
    check("cancel_after", pause_active, 1'b0);
    cyc();

    // Pause and eop in the same cycle: next sop blocked for 8 cycles.
    in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b0;
    cyc();
    in_startofpacket = 1'b0; in_endofpacket = 1'b1;
    pause_valid = 1'b1; pause_data = 16'd1;
    @(negedge clk);
    check("eop_pause_eop_pass", in_ready, 1'b1);
    cyc();
    pause_valid = 1'b0;
    in_startofpacket = 1'b1; in_endofpacket = 1'b1;
    rel = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) break;
      rel++;
      cyc();
    end
    check("eop_pause_block", rel, 8);
    cyc();
    in_valid = 1'b0;

    // Downstream backpressure, pause-free 8-beat frame.
    sb_en = 1'b1;
    for (int b = 0; b < 8; b++) begin
      beat_t bt;
      logic acc;
      bt.data = {$urandom(), $urandom()};
      bt.empty = 3'(b);
      bt.sop = (b == 0);
      bt.eop = (b == 7);
      in_valid = 1'b1; in_data = bt.data; in_empty = bt.empty;
      in_startofpacket = bt.sop; in_endofpacket = bt.eop;
      sb_q.push_back(bt);
      acc = 1'b0;
      for (int t = 0; t < 50; t++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = in_ready;
        cyc();
        if (acc) break;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL bp_accept_timeout: got no accept expected beat %0d accepted", b);
      end
    end
    sb_en = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_beat_count", sb_popped, 8);
    check("bp_queue_empty", sb_q.size(), 0);

    // Reset while paused and mid-frame.
    in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b0;
    cyc();
    in_startofpacket = 1'b0;
    pause_valid = 1'b1; pause_data = 16'd100;
    cyc();
    pause_valid = 1'b0; in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b1;
    pause_valid = 1'b1; pause_data = 16'd2;
    @(negedge clk);
    check("rst2_pause_active", pause_active, 1'b0);
    check("rst2_sop_passes", {in_ready, out_valid}, 2'b11);
`ifdef ETH_10G_TX_PAUSE_STATS_EN
    check("rst2_stats", pause_req_count, 16'd0);
`endif
    cyc();
    pause_valid = 1'b0;
    @(negedge clk);
    check("rst2_in_frame_cleared", out_valid, 1'b0);
    cyc();
    count_active(n);
    check("rst2_new_pause_len", n, 15);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_10g_mac_tx_pause_timer.md
# eth_10g_mac_tx_pause_timer

TX-side consumer of the 16-bit pause-length stream produced by the RX pause-frame decoder. Loads each received pause quanta value into a countdown timer, one quanta per `QUANTA_CYCLES` clocks. While the timer is non-zero, it stops the TX Avalon-ST packet stream at the next frame boundary. Sits between the TX packet source and the MAC TX datapath, on the MAC clock.

## Interface
- `QUANTA_CYCLES`, default 8: clocks per pause quanta (512 bit times at 64 bit/clk); legal range 1..255.
- `DATA_W`, default 64: TX data width.
- `EMPTY_W`, default 3: TX empty width.
- `clk` in 1: MAC clock; all logic single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `pause_valid` in 1: pause quanta valid. No ready; cannot be backpressured.
- `pause_data` in 16: pause quanta value.
- `in_valid`, `in_data`[DATA_W], `in_startofpacket`, `in_endofpacket`, `in_empty`[EMPTY_W]: inputs; upstream TX stream.
- `in_ready` out 1: upstream ready.
- `out_valid`, `out_data`, `out_startofpacket`, `out_endofpacket`, `out_empty`: outputs; downstream TX stream, same widths.
- `out_ready` in 1: downstream ready.
- `pause_active` out 1: timer non-zero.

## Operation
- **Counters:**
  - `quanta_cnt` is 16 bits.
  - `sub_cnt` is 8 bits, counting 0..QUANTA_CYCLES-1.
  - `pause_active` = (`quanta_cnt` != 0), registered.
- **Load:** `pause_valid` in cycle N sets `quanta_cnt`=`pause_data` and `sub_cnt`=0 at edge N+1.
  - Overrides any count in progress; no accumulation.
  - `pause_data`=0 cancels the pause.
- **Countdown:** each cycle with `quanta_cnt`!=0 and no load, `sub_cnt` increments. On wrap (`sub_cnt`==QUANTA_CYCLES-1 -> 0), `quanta_cnt` decrements.
  - `pause_active` is high for exactly Q×QUANTA_CYCLES cycles after a load of Q.
  - No wrap below 0.
- **Frame tracker:** `in_frame` register.
  - Set on an accepted beat with sop=1, eop=0.
  - Cleared on an accepted beat with eop=1.
  - A single-beat frame (sop=eop=1) leaves it 0.
- **Gate:** `gate_open` = !`pause_active` | `in_frame`.
  - `out_valid` = `in_valid` & `gate_open`.
  - `in_ready` = `out_ready` & `gate_open`.
  - Data, sop, eop and empty pass through combinationally.
  - A frame in progress always completes; a new sop beat is held, not dropped, until the pause expires.
- **Beat acceptance:** a beat is accepted when `in_valid` & `in_ready`.

## Timing
- Stream path: zero latency, purely combinational from `in_*`/`out_ready` to `out_*`/`in_ready`.
- `pause_valid` at N -> `pause_active`=1 at N+1 (if `pause_data`!=0). Blocking therefore starts with the first sop presented at or after N+1 and outside a frame.
- Expiry: `pause_active` falls on the edge ending the final quanta. A held sop beat passes in that same cycle it is first seen with `pause_active`=0.
- **Reset values:**
  - `quanta_cnt`=0, `sub_cnt`=0, `in_frame`=0, `pause_active`=0.
  - `out_valid` follows `in_valid`; `in_ready` follows `out_ready`.
- **Boundary behaviour:**
  - Reload when `quanta_cnt`==1 at wrap: the load wins.
  - Load of 0xFFFF: 65535×QUANTA_CYCLES cycles, no overflow.
  - `pause_valid` and an accepted eop in the same cycle: both take effect; the next sop is blocked.
  - `reset` mid-pause or mid-frame: all state cleared next edge; the pause is abandoned.

## Configuration
- Macro `ETH_10G_TX_PAUSE_STATS_EN`.
- **Defined:** adds output `pause_req_count` out 16, a saturating count of `pause_valid` beats with non-zero `pause_data`.
  - Increments 1 cycle after the beat.
  - Holds at 0xFFFF.
  - Cleared by `reset`.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Basic pause:** QUANTA_CYCLES=8, `pause_data`=3 at idle.
  - `pause_active` high exactly 24 cycles.
  - A sop presented during that window is held with `in_ready`=0, then accepted on the cycle `pause_active`=0.
- **Mid-frame pause:** `pause_data`=2 arrives during beat 2 of a 5-beat frame.
  - All 5 beats pass unstalled.
  - The next sop is blocked until 16 cycles after the load.
- **Reload and cancel:**
  - Load 10, then after 20 cycles load 4: `pause_active` ends 32 cycles after the second load.
  - Load 0 mid-pause: `pause_active` drops the next cycle.
- **Downstream backpressure:** `out_ready` toggling during a pause-free 8-beat frame.
  - `in_ready` mirrors `out_ready` exactly.
  - No beat lost or duplicated; data/empty match.
- **Reset:** `reset` asserted for 1 cycle while paused (quanta 100) and mid-frame.
  - Next cycle `pause_active`=0 and `in_frame`=0.
  - A new sop passes immediately.
- **Stats (macro defined):**
  - 3 non-zero and 2 zero pause beats -> `pause_req_count`=3.
  - Preloaded near saturation, it holds at 0xFFFF.
